// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-control bundle between the hazard unit and the stall controller.
// Zero-latency control signals; no backpressure, every cycle is consumed.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             nop_req;
  logic             branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             stall_error;

  modport master (
    output nop_req, branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
    input  state, stall_count, flush_count, stall_error
  );

  modport slave (
    input  nop_req, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
    output state, stall_count, flush_count, stall_error
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller with stall watchdog and saturating perf counters.
// Outputs are combinational from registered state + current inputs; no backpressure.
module pipeline_stall_ctrl #(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 3
) (
  input logic                clock,
  input logic                reset,
  pipeline_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10,
    ERROR = 2'b11
  } state_t;

  localparam int RUN_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  state_t           state_q, state_d;
  logic [RUN_W-1:0] stall_run_q, stall_run_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_error;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      stall_run_q   <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_run_q   <= stall_run_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // In FLUSH the decode slot holds the squashed bubble, so its branch decision is void.
  always_comb begin
    state_d = state_q;
    if (state_q != ERROR) begin
      if (bus.nop_req)
        state_d = (stall_run_q == RUN_MAX) ? ERROR : STALL;
      else if (bus.branch_taken && state_q != FLUSH)
        state_d = FLUSH;
      else
        state_d = RUN;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    stall_error  = (state_q == ERROR);
    if (!reset) begin
      if (state_q == ERROR) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (bus.nop_req) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (bus.branch_taken && state_q != FLUSH) begin
        if_id_flush  = 1'b1;
      end
    end
  end

  // stall_run never needs to exceed RUN_MAX: reaching it with another stall trips ERROR.
  always_comb begin
    stall_run_d   = stall_run_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (state_q != ERROR) begin
      if (bus.nop_req) begin
        stall_run_d = (stall_run_q == RUN_MAX) ? stall_run_q : stall_run_q + 1'b1;
        if (stall_count_q != '1)
          stall_count_d = stall_count_q + 1'b1;
      end else begin
        stall_run_d = '0;
      end
    end
    if (if_id_flush && flush_count_q != '1)
      flush_count_d = flush_count_q + 1'b1;
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.stall_error  = stall_error;
  assign bus.state        = state_q;
  assign bus.stall_count  = stall_count_q;
  assign bus.flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboarded bench for pipeline_stall_ctrl (CNT_W=4, MAX_STALL=3).
module tb_pipeline_stall_ctrl;

  localparam logic [1:0] S_RUN = 2'b00, S_STALL = 2'b01, S_FLUSH = 2'b10, S_ERR = 2'b11;
  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
  localparam logic [3:0] C_NORM = 4'b1100, C_BR = 4'b1110, C_STALL = 4'b0001;

  typedef struct {
    logic       rst;
    logic       nop;
    logic       br;
    logic [3:0] ctrl;
    logic [1:0] st;
    logic       err;
    logic [3:0] sc;
    logic [3:0] fc;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  vec_t sb[$];

  pipeline_stall_ctrl_if #(.CNT_W(4)) bus ();

  pipeline_stall_ctrl #(.CNT_W(4), .MAX_STALL(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic rst, logic nop, logic br, logic [3:0] ctrl,
                              logic [1:0] st, logic err, logic [3:0] sc, logic [3:0] fc);
    vec_t v;
    v.rst = rst; v.nop = nop; v.br = br; v.ctrl = ctrl;
    v.st = st; v.err = err; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; bus.nop_req = 1'b0; bus.branch_taken = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    vec_t q[$];
    vec_t v, e;
    int n = 0;
    q.push_back(mk(1, 1, 1, C_NORM, S_RUN, 0, 0, 0));
    q.push_back(mk(1, 0, 0, C_NORM, S_RUN, 0, 0, 0));
    while (q.size() > 0) begin
      v = q.pop_front();
      reset = v.rst; bus.nop_req = v.nop; bus.branch_taken = v.br;
      #1;
      checks++;
      if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} !== v.ctrl) begin
        failures++;
        $display("FAIL reset ctrl step %0d: got %b want %b", n,
                 {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble}, v.ctrl);
      end
      sb.push_back(v);
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.state, bus.stall_error, bus.stall_count, bus.flush_count} !== {e.st, e.err, e.sc, e.fc}) begin
        failures++;
        $display("FAIL reset state step %0d: got st=%b err=%b sc=%0d fc=%0d want st=%b err=%b sc=%0d fc=%0d",
                 n, bus.state, bus.stall_error, bus.stall_count, bus.flush_count, e.st, e.err, e.sc, e.fc);
      end
      n++;
    end
    reset = 1'b0;
  endtask

  task automatic test_load_use_branch();
    vec_t q[$];
    vec_t v, e;
    int n = 0;
    do_reset();
    q.push_back(mk(0, 0, 0, C_NORM,  S_RUN,   0, 0, 0));
    q.push_back(mk(0, 1, 0, C_STALL, S_STALL, 0, 1, 0));  // single load-use
    q.push_back(mk(0, 0, 0, C_NORM,  S_RUN,   0, 1, 0));
    q.push_back(mk(0, 0, 1, C_BR,    S_FLUSH, 0, 1, 1));  // taken branch
    q.push_back(mk(0, 0, 1, C_NORM,  S_RUN,   0, 1, 1));  // branch in FLUSH ignored
    q.push_back(mk(0, 1, 0, C_STALL, S_STALL, 0, 2, 1));
    q.push_back(mk(0, 0, 1, C_BR,    S_FLUSH, 0, 2, 2));  // branch out of STALL
    q.push_back(mk(0, 1, 1, C_STALL, S_STALL, 0, 3, 2));  // nop honoured in FLUSH
    q.push_back(mk(0, 0, 0, C_NORM,  S_RUN,   0, 3, 2));
    while (q.size() > 0) begin
      v = q.pop_front();
      reset = v.rst; bus.nop_req = v.nop; bus.branch_taken = v.br;
      #1;
      checks++;
      if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} !== v.ctrl) begin
        failures++;
        $display("FAIL load_use_branch ctrl step %0d: got %b want %b", n,
                 {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble}, v.ctrl);
      end
      sb.push_back(v);
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.state, bus.stall_error, bus.stall_count, bus.flush_count} !== {e.st, e.err, e.sc, e.fc}) begin
        failures++;
        $display("FAIL load_use_branch state step %0d: got st=%b err=%b sc=%0d fc=%0d want st=%b err=%b sc=%0d fc=%0d",
                 n, bus.state, bus.stall_error, bus.stall_count, bus.flush_count, e.st, e.err, e.sc, e.fc);
      end
      n++;
    end
  endtask

  task automatic test_simultaneous();
    vec_t q[$];
    vec_t v, e;
    int n = 0;
    do_reset();
    q.push_back(mk(0, 1, 1, C_STALL, S_STALL, 0, 1, 0));
    q.push_back(mk(0, 1, 1, C_STALL, S_STALL, 0, 2, 0));
    q.push_back(mk(0, 0, 0, C_NORM,  S_RUN,   0, 2, 0));
    while (q.size() > 0) begin
      v = q.pop_front();
      reset = v.rst; bus.nop_req = v.nop; bus.branch_taken = v.br;
      #1;
      checks++;
      if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} !== v.ctrl) begin
        failures++;
        $display("FAIL simultaneous ctrl step %0d: got %b want %b", n,
                 {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble}, v.ctrl);
      end
      sb.push_back(v);
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.state, bus.stall_error, bus.stall_count, bus.flush_count} !== {e.st, e.err, e.sc, e.fc}) begin
        failures++;
        $display("FAIL simultaneous state step %0d: got st=%b err=%b sc=%0d fc=%0d want st=%b err=%b sc=%0d fc=%0d",
                 n, bus.state, bus.stall_error, bus.stall_count, bus.flush_count, e.st, e.err, e.sc, e.fc);
      end
      n++;
    end
  endtask

  task automatic test_watchdog_and_reset();
    vec_t q[$];
    vec_t v, e;
    int n = 0;
    do_reset();
    q.push_back(mk(0, 1, 0, C_STALL, S_STALL, 0, 1, 0));
    q.push_back(mk(0, 1, 0, C_STALL, S_STALL, 0, 2, 0));
    q.push_back(mk(0, 1, 0, C_STALL, S_STALL, 0, 3, 0));
    q.push_back(mk(0, 1, 0, C_STALL, S_ERR,   1, 4, 0));  // 4th consecutive stall trips
    q.push_back(mk(0, 0, 1, C_STALL, S_ERR,   1, 4, 0));  // ERROR ignores inputs
    q.push_back(mk(0, 1, 1, C_STALL, S_ERR,   1, 4, 0));
    q.push_back(mk(0, 0, 0, C_STALL, S_ERR,   1, 4, 0));
    q.push_back(mk(1, 1, 0, C_NORM,  S_RUN,   0, 0, 0));  // reset out of ERROR
    q.push_back(mk(0, 0, 1, C_BR,    S_FLUSH, 0, 0, 1));
    q.push_back(mk(0, 1, 0, C_STALL, S_STALL, 0, 1, 1));
    q.push_back(mk(0, 1, 0, C_STALL, S_STALL, 0, 2, 1));
    q.push_back(mk(1, 1, 1, C_NORM,  S_RUN,   0, 0, 0));  // reset mid-stall
    q.push_back(mk(0, 0, 0, C_NORM,  S_RUN,   0, 0, 0));
    while (q.size() > 0) begin
      v = q.pop_front();
      reset = v.rst; bus.nop_req = v.nop; bus.branch_taken = v.br;
      #1;
      checks++;
      if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} !== v.ctrl) begin
        failures++;
        $display("FAIL watchdog ctrl step %0d: got %b want %b", n,
                 {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble}, v.ctrl);
      end
      sb.push_back(v);
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.state, bus.stall_error, bus.stall_count, bus.flush_count} !== {e.st, e.err, e.sc, e.fc}) begin
        failures++;
        $display("FAIL watchdog state step %0d: got st=%b err=%b sc=%0d fc=%0d want st=%b err=%b sc=%0d fc=%0d",
                 n, bus.state, bus.stall_error, bus.stall_count, bus.flush_count, e.st, e.err, e.sc, e.fc);
      end
      n++;
    end
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    vec_t q[$];
    vec_t v, e;
    int n = 0;
    int stalls = 0;
    do_reset();
    // 20 stall cycles in runs of at most 3 so the watchdog never fires
    for (int g = 0; g < 7; g++) begin
      for (int k = 0; k < 3 && stalls < 20; k++) begin
        stalls++;
        q.push_back(mk(0, 1, 0, C_STALL, S_STALL, 0, 4'((stalls > 15) ? 15 : stalls), 0));
      end
      q.push_back(mk(0, 0, 0, C_NORM, S_RUN, 0, 4'((stalls > 15) ? 15 : stalls), 0));
    end
    while (q.size() > 0) begin
      v = q.pop_front();
      reset = v.rst; bus.nop_req = v.nop; bus.branch_taken = v.br;
      #1;
      checks++;
      if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} !== v.ctrl) begin
        failures++;
        $display("FAIL saturation ctrl step %0d: got %b want %b", n,
                 {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble}, v.ctrl);
      end
      sb.push_back(v);
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.state, bus.stall_error, bus.stall_count, bus.flush_count} !== {e.st, e.err, e.sc, e.fc}) begin
        failures++;
        $display("FAIL saturation state step %0d: got st=%b err=%b sc=%0d fc=%0d want st=%b err=%b sc=%0d fc=%0d",
                 n, bus.state, bus.stall_error, bus.stall_count, bus.flush_count, e.st, e.err, e.sc, e.fc);
      end
      n++;
    end
    checks++;
    if (bus.stall_count !== 4'd15) begin
      failures++;
      $display("FAIL saturation final: got sc=%0d want 15", bus.stall_count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.nop_req = 1'b0;
    bus.branch_taken = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_load_use_branch();
    test_simultaneous();
    test_watchdog_and_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
